tag_rsdp_fold: RTL and testbench

Parametrised, folded successor of the single-cycle RSDP tag inner-product unit. Computes u = sum over i<N of (-1)^s_i * 2^r_i * ch_i mod 127. Each secret entry is 4 bits {s_i, r_i[2:0]}; each challenge entry is 7 bits. The challenge is streamed LANES entries per beat over a valid/ready handshake, and one tag is produced per challenge row. It sits between the challenge source and the response packer in the prover datapath, and replaces the fixed 34-wide combinational tree.

---
 rtl/tag_rsdp_fold.sv | 156 +++++++++++++++
 tb/tb_tag_rsdp_fold.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_rsdp_fold.sv
// tag_rsdp_fold
//   Folded RSDP tag inner product: u = sum_i (-1)^s_i * 2^r_i * ch_i mod 127.
//   The challenge row arrives LANES entries per beat; one tag is produced per row.
//   Arithmetic is ones'-complement mod 127 (end-around carry), so 0 and 127
//   both encode zero internally; CANON=1 maps a final 127 to 0.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   sec_load   load sec_in into the secret register (only while idle)
//   sec_in     secret, element i = {sign, rot[2:0]} at sec_in[4i+3:4i]
//   in_valid   challenge beat valid
//   in_ready   block accepts a challenge beat
//   in_data    challenge beat, lane k = in_data[7k+6:7k]
//   out_valid  tag available
//   out_ready  consumer accepts the tag
//   out_u      tag value (GF(127) residue)
//   busy       row partially accumulated or tag pending
module tag_rsdp_fold #(
    parameter int N     = 34,
    parameter int LANES = 8,
    parameter int CANON = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sec_load,
    input  logic [4*N-1:0]     sec_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [6:0]         out_u,
    output logic               busy
);

    localparam int BEATS = (N + LANES - 1) / LANES;
    localparam int PADN  = BEATS * LANES;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic {
        ST_ACC = 1'b0,
        ST_OUT = 1'b1
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_beat_cnt;
    logic [6:0]         r_acc;
    logic [6:0]         r_out_u;
    logic               r_out_valid;
    logic               r_in_ready;
    logic [4*N-1:0]     r_sec;

    logic [4*PADN-1:0]  w_sec_pad;
    logic [6:0]         w_beat_sum;
    logic [6:0]         w_final;
    logic [6:0]         w_tag;
    logic               w_fire;
    logic               w_last;
    logic               w_sec_take;
    int                 w_idx;
    logic [3:0]         w_lane_sec;
    logic [6:0]         w_lane_rot;

    // Ones'-complement add mod 127: fold the carry back into bit 0.
    function automatic logic [6:0] oc_add(input logic [6:0] a, input logic [6:0] b);
        logic [7:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[7] ? (s[6:0] + 7'd1) : s[6:0];
    endfunction

    // 7-bit left rotate == multiply by 2^r mod 127; r=7 is a full turn (identity).
    function automatic logic [6:0] rotl7(input logic [6:0] ch, input logic [2:0] r);
        logic [13:0] t;
        t = {ch, ch} << r;
        return t[13:7];
    endfunction

    // Secret padded to a whole number of beats so the per-lane select never runs off the end.
    always_comb begin
        w_sec_pad          = '0;
        w_sec_pad[4*N-1:0] = r_sec;
    end

    // Per-beat reduction; lanes past element N-1 on the last beat are skipped.
    always_comb begin
        w_beat_sum = '0;
        w_idx      = 0;
        w_lane_sec = '0;
        w_lane_rot = '0;
        for (int k = 0; k < LANES; k++) begin
            w_idx      = int'(r_beat_cnt) * LANES + k;
            w_lane_sec = w_sec_pad[w_idx*4 +: 4];
            w_lane_rot = rotl7(in_data[7*k +: 7], w_lane_sec[2:0]);
            if (w_idx < N) begin
                w_beat_sum = oc_add(w_beat_sum, w_lane_sec[3] ? ~w_lane_rot : w_lane_rot);
            end
        end
    end

    assign w_final    = oc_add(r_acc, w_beat_sum);
    assign w_tag      = ((CANON != 0) && (w_final == 7'h7F)) ? 7'd0 : w_final;
    assign w_fire     = in_valid && r_in_ready;
    assign w_last     = (r_beat_cnt == LAST_BEAT);
    // A beat in the same cycle wins over a load.
    assign w_sec_take = sec_load && (r_state == ST_ACC) && (r_beat_cnt == '0) && !w_fire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACC;
            r_beat_cnt  <= '0;
            r_acc       <= '0;
            r_out_u     <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_sec       <= '0;
        end else begin
            unique case (r_state)
                ST_ACC: begin
                    r_in_ready <= 1'b1;
                    if (w_sec_take) begin
                        r_sec <= sec_in;
                    end
                    if (w_fire) begin
                        if (w_last) begin
                            r_out_u     <= w_tag;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_beat_cnt  <= '0;
                            r_in_ready  <= 1'b0;
                            r_state     <= ST_OUT;
                        end else begin
                            r_acc      <= w_final;
                            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_OUT: begin
                    r_in_ready <= 1'b0;
                    if (r_out_valid && out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_ACC;
                    end
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_u     = r_out_u;
    assign busy      = (r_beat_cnt != '0) || (r_state == ST_OUT);

endmodule

// File: tb/tb_tag_rsdp_fold.sv
module tb_tag_rsdp_fold;

    localparam int N     = 34;
    localparam int LANES = 8;
    localparam int BEATS = 5;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               sec_load;
    logic [4*N-1:0]     sec_in;
    logic               in_valid;
    logic [7*LANES-1:0] in_data;
    logic               out_ready;
    logic               in_ready, out_valid, busy;
    logic [6:0]         out_u;
    logic               in_ready_r, out_valid_r, busy_r;
    logic [6:0]         out_u_r;

    int n_vec = 0;
    int n_err = 0;

    tag_rsdp_fold #(.N(N), .LANES(LANES), .CANON(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .sec_load(sec_load), .sec_in(sec_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_u(out_u), .busy(busy)
    );

    tag_rsdp_fold #(.N(N), .LANES(LANES), .CANON(0)) u_raw (
        .clk(clk), .rst_n(rst_n), .sec_load(sec_load), .sec_in(sec_in),
        .in_valid(in_valid), .in_ready(in_ready_r), .in_data(in_data),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_u(out_u_r), .busy(busy_r)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4*N-1:0] sec;
        logic [7*N-1:0] ch;
        logic [6:0]     pad;
        logic [6:0]     exp_c;
        logic [6:0]     exp_r;
        int             stall;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: signed weighted sum reduced mod 127 with integer arithmetic.
    // Without canonicalisation, a zero result reads as 127 unless every
    // element's signed product is the all-zero word (s=0,ch=0 or s=1,ch=127).
    function automatic void model(input logic [4*N-1:0] sec, input logic [7*N-1:0] ch,
                                  output logic [6:0] ec, output logic [6:0] er);
        int v, t, c, r;
        bit s, allz;
        v = 0;
        allz = 1'b1;
        for (int i = 0; i < N; i++) begin
            s = sec[4*i+3];
            r = int'(sec[4*i +: 3]);
            c = int'(ch[7*i +: 7]);
            t = (c * (1 << r)) % 127;
            v = s ? v - t : v + t;
            if (s ? (c != 127) : (c != 0)) allz = 1'b0;
        end
        v  = ((v % 127) + 127) % 127;
        ec = 7'(v);
        er = (v == 0 && !allz) ? 7'd127 : 7'(v);
    endfunction

    function automatic logic [7*LANES-1:0] beat_data(input logic [7*N-1:0] ch, input int b,
                                                      input logic [6:0] pad);
        logic [7*LANES-1:0] d;
        int idx;
        for (int k = 0; k < LANES; k++) begin
            idx = b * LANES + k;
            d[7*k +: 7] = (idx < N) ? ch[7*idx +: 7] : pad;
        end
        return d;
    endfunction

    task automatic load_sec(input logic [4*N-1:0] s);
        in_valid = 1'b0;
        chk("idle_busy_before_load", int'(busy), 0);
        sec_in   = s;
        sec_load = 1'b1;
        @(negedge clk);
        sec_load = 1'b0;
    endtask

    task automatic send_beat(input logic [7*N-1:0] ch, input logic [6:0] pad, input int b);
        in_valid = 1'b1;
        in_data  = beat_data(ch, b, pad);
        chk("in_ready_on_beat", int'(in_ready), 1);
        @(negedge clk);
    endtask

    task automatic send_row(input logic [7*N-1:0] ch, input logic [6:0] pad, input bit gaps);
        for (int b = 0; b < BEATS; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            send_beat(ch, pad, b);
        end
        in_valid = 1'b0;
    endtask

    // Called on the first negedge after the last beat was accepted.
    task automatic check_out(input string nm, input logic [6:0] ec, input logic [6:0] er,
                             input int stall);
        chk({nm, "_out_valid"}, int'(out_valid), 1);
        chk({nm, "_out_valid_raw"}, int'(out_valid_r), 1);
        chk({nm, "_out_u"}, int'(out_u), int'(ec));
        chk({nm, "_out_u_raw"}, int'(out_u_r), int'(er));
        chk({nm, "_in_ready_out"}, int'(in_ready), 0);
        chk({nm, "_busy_out"}, int'(busy), 1);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({nm, "_stall_valid"}, int'(out_valid), 1);
            chk({nm, "_stall_u"}, int'(out_u), int'(ec));
            chk({nm, "_stall_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, "_valid_drop"}, int'(out_valid), 0);
        chk({nm, "_in_ready_back"}, int'(in_ready), 1);
        chk({nm, "_busy_idle"}, int'(busy), 0);
    endtask

    initial begin
        logic [4*N-1:0] sa, sb;
        logic [7*N-1:0] ch;
        logic [6:0]     ec, er, ec2, er2, pad;
        int             kind;

        rst_n     = 1'b0;
        sec_load  = 1'b0;
        sec_in    = '0;
        in_valid  = 1'b1;
        in_data   = 56'h7F_7F_7F_7F_7F_7F_7F;
        out_ready = 1'b0;

        // Reset with in_valid held high
        repeat (3) begin
            @(negedge clk);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_u", int'(out_u), 0);
            chk("rst_busy", int'(busy), 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(in_ready), 1);
        chk("rel_busy_no_beat", int'(busy), 0);
        in_valid = 1'b0;

        // Secret register resets to zero: plain sum of the challenge
        for (int i = 0; i < N; i++) ch[7*i +: 7] = 7'($urandom);
        model('0, ch, ec, er);
        send_row(ch, 7'h00, 1'b0);
        check_out("sec_reset_zero", ec, er, 0);

        // Directed table
        for (int t = 0; t < 6; t++) begin
            tbl[t].sec = '0; tbl[t].ch = '0; tbl[t].pad = 7'h00; tbl[t].stall = 0;
        end
        for (int i = 0; i < N; i++) tbl[0].ch[7*i +: 7] = 7'd1;
        tbl[0].exp_c = 7'd34;  tbl[0].exp_r = 7'd34;
        tbl[1].sec[3:0] = 4'b0001; tbl[1].ch[6:0] = 7'd64;
        tbl[1].exp_c = 7'd1;   tbl[1].exp_r = 7'd1;
        tbl[2].sec[3:0] = 4'b0110; tbl[2].ch[6:0] = 7'd3;
        tbl[2].exp_c = 7'd65;  tbl[2].exp_r = 7'd65;
        tbl[3].sec[3:0] = 4'b1000; tbl[3].ch[6:0] = 7'd5;
        tbl[3].exp_c = 7'd122; tbl[3].exp_r = 7'd122;
        tbl[4].sec[3:0] = 4'b1000;
        tbl[4].exp_c = 7'd0;   tbl[4].exp_r = 7'd127;
        tbl[5].sec = '1; tbl[5].pad = 7'h7F; tbl[5].stall = 3;
        tbl[5].exp_c = 7'd0;   tbl[5].exp_r = 7'd127;

        for (int t = 0; t < 6; t++) begin
            load_sec(tbl[t].sec);
            send_row(tbl[t].ch, tbl[t].pad, 1'b0);
            check_out($sformatf("table%0d", t), tbl[t].exp_c, tbl[t].exp_r, tbl[t].stall);
        end

        // sec_load mid-row is ignored
        for (int i = 0; i < N; i++) ch[7*i +: 7] = 7'($urandom_range(1, 126));
        for (int i = 0; i < N; i++) sa[4*i +: 4] = 4'($urandom);
        model(sa, ch, ec, er);
        do begin
            for (int i = 0; i < N; i++) sb[4*i +: 4] = 4'($urandom);
            model(sb, ch, ec2, er2);
        end while (ec2 == ec);
        load_sec(sa);
        send_beat(ch, 7'h00, 0);
        send_beat(ch, 7'h00, 1);
        in_valid = 1'b0;
        sec_in   = sb;
        sec_load = 1'b1;
        @(negedge clk);
        sec_load = 1'b0;
        chk("gate_busy_mid_row", int'(busy), 1);
        for (int b = 2; b < BEATS; b++) send_beat(ch, 7'h00, b);
        in_valid = 1'b0;
        check_out("load_mid_row", ec, er, 0);

        // sec_load coinciding with the first beat is ignored
        sec_in   = sb;
        sec_load = 1'b1;
        send_beat(ch, 7'h00, 0);
        sec_load = 1'b0;
        for (int b = 1; b < BEATS; b++) send_beat(ch, 7'h00, b);
        in_valid = 1'b0;
        check_out("load_with_beat", ec, er, 0);

        // Idle load takes effect
        load_sec(sb);
        send_row(ch, 7'h00, 1'b0);
        check_out("load_idle", ec2, er2, 0);

        // Reset after three beats discards the partial sum
        load_sec(sa);
        for (int b = 0; b < 3; b++) send_beat(ch, 7'h00, b);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrow_rst_busy", int'(busy), 0);
        chk("midrow_rst_valid", int'(out_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrow_rel_in_ready", int'(in_ready), 1);
        load_sec(sa);
        send_row(ch, 7'h00, 1'b0);
        check_out("after_midrow_rst", ec, er, 0);

        // Reset while a tag is pending drops it
        send_row(ch, 7'h00, 1'b0);
        chk("out_rst_pre_valid", int'(out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("out_rst_valid", int'(out_valid), 0);
        chk("out_rst_valid_raw", int'(out_valid_r), 0);
        chk("out_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("out_rel_in_ready", int'(in_ready), 1);

        // Randomized rows against the reference model
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 4);
            for (int i = 0; i < N; i++) begin
                sa[4*i +: 4] = 4'($urandom);
                if (kind == 0)
                    ch[7*i +: 7] = sa[4*i+3] ? 7'h7F : 7'h00;
                else if ($urandom_range(0, 3) == 0)
                    ch[7*i +: 7] = $urandom_range(0, 1) ? 7'h7F : 7'h00;
                else
                    ch[7*i +: 7] = 7'($urandom);
            end
            pad = 7'($urandom);
            model(sa, ch, ec, er);
            load_sec(sa);
            send_row(ch, pad, 1'b1);
            check_out($sformatf("rand%0d", n), ec, er, $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
